// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC register, IF/ID capture, branch/jump redirect, self-halt on HALT_INST.
// Optional fetch counter under FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        jump_id;
  logic [31:0] jump_target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
`endif

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_id     = valid_q && ((inst_q[31:26] == 6'b000010) || (inst_q[31:26] == 6'b000011));
  assign jump_target = {pc4_q[31:28], inst_q[25:0], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
`ifdef FETCH_PERF_CNT_EN
    fetch_cnt_d = fetch_cnt_q;
`endif
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        inst_d  = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end
      ST_RUN: begin
        if (br_taken) begin
          pc_d    = {br_target[31:2], 2'b00};
          inst_d  = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end else if (stall) begin
          // Everything holds, including a jump waiting in ID.
          pc_d = pc_q;
        end else if (jump_id) begin
          pc_d    = jump_target;
          inst_d  = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end else if (inst_in == HALT_INST) begin
          state_d = ST_HALT;
          inst_d  = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_plus4;
          inst_d  = inst_in;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
`ifdef FETCH_PERF_CNT_EN
          fetch_cnt_d = fetch_cnt_q + 32'd1;
`endif
        end
      end
      ST_HALT: begin
        inst_d  = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q <= fetch_cnt_d;
`endif
    end
  end

  assign inst_addr   = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
`ifdef FETCH_PERF_CNT_EN
  assign fetch_cnt   = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a 32-word ROM model on inst_addr[6:2].
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  logic [31:0] rom [0:31];
  int checks;
  int passes;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .inst_addr  (inst_addr),
    .inst_in    (inst_in),
    .if_id_inst (if_id_inst),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid),
    .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
    ,.fetch_cnt (fetch_cnt)
`endif
  );

  assign inst_in = rom[inst_addr[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    rom[1]  = 32'h3c02_5678;
    rom[2]  = 32'h2442_0001;
    rom[3]  = 32'hFFFF_FFFF;
    rom[16] = 32'h0800_0010;
    rom[31] = 32'h0042_1020;
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;

    // Reset state
    step();
    chk("rst_addr",  inst_addr, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_inst",  if_id_inst, 32'h0);
    chk("rst_pc4",   if_id_pc4, 32'h0);
    chk("rst_halt",  {31'b0, halted}, 32'h0);
    rst = 1'b0;

    // BOOT cycle
    step();
    chk("boot_valid", {31'b0, if_id_valid}, 32'h0);
    chk("boot_addr",  inst_addr, 32'h0);

    step();
    chk("f0_inst",  if_id_inst, 32'h0);
    chk("f0_pc4",   if_id_pc4, 32'h4);
    chk("f0_valid", {31'b0, if_id_valid}, 32'h1);
    step();
    chk("f1_inst", if_id_inst, 32'h3c02_5678);
    chk("f1_pc4",  if_id_pc4, 32'h8);
    chk("f1_addr", inst_addr, 32'h8);

    // Stall three cycles at PC=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", inst_addr, 32'h8);
      chk("stall_inst", if_id_inst, 32'h3c02_5678);
      chk("stall_pc4",  if_id_pc4, 32'h8);
    end
    stall = 1'b0;
    step();
    chk("unstall_addr", inst_addr, 32'hC);
    chk("unstall_inst", if_id_inst, 32'h2442_0001);
    chk("unstall_pc4",  if_id_pc4, 32'hC);

    // Branch with stall; halt word at PC=12 is also overridden
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0042;
    step();
    chk("br_addr",  inst_addr, 32'h40);
    chk("br_valid", {31'b0, if_id_valid}, 32'h0);
    chk("br_nohalt", {31'b0, halted}, 32'h0);
    stall = 1'b0; br_taken = 1'b0;

    // Jump in ID, held by stall first
    step();
    chk("j_fetch_inst", if_id_inst, 32'h0800_0010);
    chk("j_fetch_addr", inst_addr, 32'h44);
    stall = 1'b1;
    step();
    chk("j_stall_addr",  inst_addr, 32'h44);
    chk("j_stall_valid", {31'b0, if_id_valid}, 32'h1);
    stall = 1'b0;
    step();
    chk("j_taken_addr",  inst_addr, 32'h40);
    chk("j_taken_valid", {31'b0, if_id_valid}, 32'h0);
    step();
    chk("j_refetch", if_id_inst, 32'h0800_0010);
    br_taken = 1'b1; br_target = 32'h0000_0080;
    step();
    chk("j_vs_br_addr",  inst_addr, 32'h80);
    chk("j_vs_br_valid", {31'b0, if_id_valid}, 32'h0);

    // PC wrap at top of address space
    br_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre", inst_addr, 32'hFFFF_FFFC);
    br_taken = 1'b0;
    step();
    chk("wrap_addr", inst_addr, 32'h0);
    chk("wrap_pc4",  if_id_pc4, 32'h0);
    chk("wrap_inst", if_id_inst, 32'h0042_1020);

    // Halt at PC=12
    br_taken = 1'b1; br_target = 32'h0000_000C;
    step();
    br_taken = 1'b0;
    step();
    chk("halt_flag",  {31'b0, halted}, 32'h1);
    chk("halt_addr",  inst_addr, 32'hC);
    chk("halt_valid", {31'b0, if_id_valid}, 32'h0);
    step();
    step();
    chk("halt_hold_addr",  inst_addr, 32'hC);
    chk("halt_hold_valid", {31'b0, if_id_valid}, 32'h0);
    br_taken = 1'b1; br_target = 32'h0000_0040;
    step();
    chk("halt_br_addr", inst_addr, 32'hC);
    chk("halt_br_flag", {31'b0, halted}, 32'h1);
    br_taken = 1'b0;

    // Reset out of HALT
    rst = 1'b1;
    step();
    chk("rst2_addr", inst_addr, 32'h0);
    chk("rst2_halt", {31'b0, halted}, 32'h0);
    rst = 1'b0;
    step();
    chk("boot2_valid", {31'b0, if_id_valid}, 32'h0);
    step();
    chk("rst2_f0_valid", {31'b0, if_id_valid}, 32'h1);
    chk("rst2_f0_pc4",   if_id_pc4, 32'h4);

`ifdef FETCH_PERF_CNT_EN
    // Counter: 5 fetches, 2 stall cycles, 1 flush
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("cnt_boot", fetch_cnt, 32'h0);
    step(); step(); step();
    stall = 1'b1;
    step(); step();
    stall = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0100;
    step();
    br_taken = 1'b0;
    step(); step();
    chk("cnt_five", fetch_cnt, 32'd5);
    chk("cnt_addr", inst_addr, 32'h108);
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    step();
    chk("cnt_wrap", fetch_cnt, 32'h0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM. Holds the program counter and drives the ROM word address.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles pipeline stall, taken-branch redirect from EX, J/JAL redirect decoded locally from IF/ID, and self-halt on a sentinel instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- HALT_INST, 32'hFFFF_FFFF, instruction word that stops fetch when captured.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard hold from decode; freezes PC and IF/ID.
- br_taken  in  1  taken branch resolved in EX; flushes IF/ID.
- br_target  in  32  branch destination byte address.
- inst_addr  out  32  byte address to ROM addr; equals PC, combinational from the PC register.
- inst_in  in  32  instruction from ROM Inst; combinational read of inst_addr.
- if_id_inst  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of if_id_inst.
- if_id_valid  out  1  high when if_id_inst is a real fetched instruction.
- halted  out  1  high while in HALT state.

Behaviour:
- Reset is synchronous and active-high: on any clk edge with rst=1, all registers are reset regardless of other inputs.
  - pc = RESET_PC
  - if_id_inst = 0 (NOP), if_id_pc4 = 0, if_id_valid = 0
  - halted = 0, state = BOOT
- Reset asserted mid-operation (including in HALT) takes effect on that edge; no pending redirect survives.
- States:
  - BOOT: one cycle; PC held; IF/ID loads NOP with valid=0; next state is RUN. BOOT gives the ROM a full cycle on RESET_PC.
  - RUN: normal fetch.
  - HALT: PC frozen; IF/ID loads NOP with valid=0 every cycle; halted=1. HALT is left only by rst.
- jump_id = if_id_valid & (if_id_inst[31:26] == 6'b000010 or 6'b000011).
- jump_target = {if_id_pc4[31:28], if_id_inst[25:0], 2'b00}.
- Per-edge priority in RUN, highest first:
  1. br_taken: pc <= {br_target[31:2], 2'b00}; IF/ID <= NOP, valid=0. Overrides stall, jump_id and halt detection.
  2. stall: pc, if_id_inst, if_id_pc4 and if_id_valid all hold. A jump sitting in ID waits until stall drops.
  3. jump_id: pc <= jump_target; IF/ID <= NOP, valid=0. The sequential slot instruction is squashed; there is no delay slot.
  4. inst_in == HALT_INST: state <= HALT; pc holds; IF/ID <= NOP, valid=0. The halt word itself never reaches decode.
  5. Otherwise: pc <= pc+4; if_id_inst <= inst_in; if_id_pc4 <= pc+4; if_id_valid <= 1.
- br_taken in HALT is ignored.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0. The ROM uses addr[6:2], so fetch wraps every 32 words; no out-of-range detection.
- Latency: an instruction at PC X appears on if_id_inst one edge after PC=X, when not stalled. A redirect shows its target on inst_addr the cycle after the redirecting edge, and its first valid instruction in IF/ID one cycle later.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt [31:0], reset to 0.
  - Increments by 1 on every edge where IF/ID loads a valid instruction (rule 5 only).
  - Wraps at 2^32.
  - Held during stall, BOOT and HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, ROM[0]=32'h0, ROM[1]=32'h3c025678 (lui), no stall:
  - BOOT cycle: valid=0, inst_addr=0.
  - Then if_id_inst=0, pc4=4.
  - Then if_id_inst=32'h3c025678, pc4=8, inst_addr=8.
- Stall held 3 cycles while PC=8: inst_addr stays 8 and IF/ID is unchanged for 3 cycles. After release, PC advances to 12 on the next edge.
- br_taken=1 with br_target=32'h0000_0042 together with stall=1: pc becomes 32'h40 and IF/ID goes valid=0. Stall is overridden and the low bits are forced to 00.
- IF/ID holds 32'h08000010 (j): next edge pc = {pc4[31:28], 26'h10, 2'b00} = 32'h40 and IF/ID is squashed. With br_taken on the same edge, br_target wins.
- ROM word at PC 12 is HALT_INST:
  - halted=1 and inst_addr stays 12; valid stays 0 indefinitely.
  - br_taken is ignored while halted.
  - rst returns PC to RESET_PC with halted=0.
- With FETCH_PERF_CNT_EN defined: 5 sequential fetches, 2 stall cycles, 1 branch flush → fetch_cnt=5. Also preload the counter near 32'hFFFF_FFFF and check the wrap to 0.
